// File: rtl/rv_core_sequencer_pkg.sv
// Shared types for the RV32 multi-cycle sequencer: FSM states, opcodes,
// instruction-field views, ALU operand bundle and decode result.
package rv_core_sequencer_pkg;

  typedef enum logic [2:0] {
    READ_COMMAND     = 3'd0,
    READ_REGISTER    = 3'd1,
    RUN_COMMAND      = 3'd2,
    WATING_MEMORY    = 3'd3,
    SAVE_IN_REGISTER = 3'd4,
    ERROR            = 3'd5
  } PROCESSOR_STATE;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [2:0] F3_WORD   = 3'b010;

  typedef struct packed {
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } R_TYPE_ALU32_INPUT;

  typedef struct packed {
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } I_TYPE;

  typedef struct packed {
    logic [6:0] imm_hi;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] imm_lo;
    logic [6:0] opcode;
  } S_TYPE;

  // Two field views of the same instruction word.
  typedef union packed {
    I_TYPE       i;
    S_TYPE       s;
    logic [31:0] raw;
  } INSTR_WORD;

  typedef struct packed {
    logic               is_op;
    logic               is_load;
    logic               is_store;
    logic               illegal;
    logic signed [31:0] imm;
  } DECODE_RESULT;

  function automatic logic signed [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/rv_core_sequencer_if.sv
// Bus bundle between the sequencer and its instruction memory, data memory,
// register file and ALU.
interface rv_core_sequencer_if;
  import rv_core_sequencer_pkg::*;

  logic              imem_req;
  logic [31:0]       imem_addr;
  logic              imem_ready;
  logic [31:0]       imem_rdata;
  logic [4:0]        rf_rs1_addr;
  logic [4:0]        rf_rs2_addr;
  logic [31:0]       rf_rs1_data;
  logic [31:0]       rf_rs2_data;
  R_TYPE_ALU32_INPUT alu_in;
  logic [31:0]       alu_result;
  logic              dmem_req;
  logic              dmem_we;
  logic [31:0]       dmem_addr;
  logic [31:0]       dmem_wdata;
  logic              dmem_ready;
  logic [31:0]       dmem_rdata;
  logic              rf_we;
  logic [4:0]        rf_wd_addr;
  logic [31:0]       rf_wd_data;

  modport master (
    output imem_req, imem_addr, rf_rs1_addr, rf_rs2_addr, alu_in,
           dmem_req, dmem_we, dmem_addr, dmem_wdata, rf_we, rf_wd_addr, rf_wd_data,
    input  imem_ready, imem_rdata, rf_rs1_data, rf_rs2_data, alu_result,
           dmem_ready, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, rf_rs1_addr, rf_rs2_addr, alu_in,
           dmem_req, dmem_we, dmem_addr, dmem_wdata, rf_we, rf_wd_addr, rf_wd_data,
    output imem_ready, imem_rdata, rf_rs1_data, rf_rs2_data, alu_result,
           dmem_ready, dmem_rdata
  );

endinterface

// File: rtl/rv_core_sequencer_decode.sv
// Combinational instruction decoder: classifies OP/LW/SW, extracts the
// sign-extended memory immediate and the register addresses.
module rv_instr_decode
  import rv_core_sequencer_pkg::*;
(
  input  logic [31:0]  ir,
  output DECODE_RESULT dec,
  output logic [4:0]   rs1_addr,
  output logic [4:0]   rs2_addr,
  output logic [4:0]   rd_addr
);

  INSTR_WORD word;

  assign word     = INSTR_WORD'(ir);
  assign rs1_addr = word.i.rs1;
  assign rs2_addr = word.s.rs2;
  assign rd_addr  = word.i.rd;

  always_comb begin
    dec = '0;
    case (word.i.opcode)
      OPC_OP: dec.is_op = 1'b1;
      OPC_LOAD: begin
        if (word.i.funct3 == F3_WORD) begin
          dec.is_load = 1'b1;
          dec.imm     = sext12(word.i.imm);
        end
      end
      OPC_STORE: begin
        if (word.s.funct3 == F3_WORD) begin
          dec.is_store = 1'b1;
          dec.imm      = sext12({word.s.imm_hi, word.s.imm_lo});
        end
      end
      default: ;
    endcase
    dec.illegal = ~(dec.is_op | dec.is_load | dec.is_store);
  end

endmodule

// File: rtl/rv_core_sequencer.sv
// Multi-cycle control FSM for the RV32 core: fetch, register read, execute,
// memory wait and write-back for R-type OP, LW and SW.
module rv_core_sequencer
  import rv_core_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rv_core_sequencer_if.master  bus,
  output logic [31:0]          pc,
  output logic [2:0]           state,
  output logic                 error
);

  localparam bit          TIMEOUT_EN  = (MEM_TIMEOUT != 0);
  localparam logic [15:0] TIMEOUT_CNT = MEM_TIMEOUT[15:0];

  PROCESSOR_STATE state_q, state_d;
  logic           started_q;
  logic [31:0]    pc_q;
  logic [31:0]    ir_q;
  logic [15:0]    wait_cnt_q;

  logic [31:0]    op1_q, op2_q;
  logic [31:0]    wb_data_q;
  logic [31:0]    mem_addr_q;

  DECODE_RESULT   dec;
  logic [4:0]     rs1_addr, rs2_addr, rd_addr;
  logic [31:0]    eff_addr;

  logic           imem_req, dmem_req;
  logic           fetch_done, mem_done;
  logic           req_wait, wait_expired;
  logic           pc_advance;

  rv_instr_decode u_decode (
    .ir       (ir_q),
    .dec      (dec),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rd_addr  (rd_addr)
  );

  // Requests depend only on registered state, never on an input.
  assign imem_req     = started_q && (state_q == READ_COMMAND);
  assign dmem_req     = (state_q == WATING_MEMORY);
  assign fetch_done   = imem_req && bus.imem_ready;
  assign mem_done     = dmem_req && bus.dmem_ready;
  assign req_wait     = (imem_req && !bus.imem_ready) || (dmem_req && !bus.dmem_ready);
  assign wait_expired = TIMEOUT_EN && req_wait && ((wait_cnt_q + 16'd1) == TIMEOUT_CNT);
  assign eff_addr     = op1_q + $unsigned(dec.imm);

  always_comb begin
    state_d    = state_q;
    pc_advance = 1'b0;
    case (state_q)
      READ_COMMAND: begin
        if (fetch_done) state_d = READ_REGISTER;
      end
      READ_REGISTER: begin
        state_d = dec.illegal ? ERROR : RUN_COMMAND;
      end
      RUN_COMMAND: begin
        if (dec.is_op)                state_d = SAVE_IN_REGISTER;
        else if (eff_addr[1:0] != '0) state_d = ERROR;
        else                          state_d = WATING_MEMORY;
      end
      WATING_MEMORY: begin
        if (mem_done) begin
          if (dec.is_load) begin
            state_d = SAVE_IN_REGISTER;
          end else begin
            state_d    = READ_COMMAND;
            pc_advance = 1'b1;
          end
        end
      end
      SAVE_IN_REGISTER: begin
        state_d    = READ_COMMAND;
        pc_advance = 1'b1;
      end
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase
    if (wait_expired) state_d = ERROR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= READ_COMMAND;
      started_q  <= 1'b0;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      if (fetch_done) ir_q <= bus.imem_rdata;
      if (pc_advance) pc_q <= pc_q + 32'd4;
      if (state_d != state_q)          wait_cnt_q <= '0;
      else if (TIMEOUT_EN && req_wait) wait_cnt_q <= wait_cnt_q + 16'd1;
    end
  end

  // Datapath registers carry no reset; the FSM never consumes them before loading.
  always_ff @(posedge clk) begin
    if (state_q == READ_REGISTER) begin
      op1_q <= bus.rf_rs1_data;
      op2_q <= bus.rf_rs2_data;
    end
    if (state_q == RUN_COMMAND) begin
      wb_data_q  <= bus.alu_result;
      mem_addr_q <= eff_addr;
    end
    if (mem_done && dec.is_load) wb_data_q <= bus.dmem_rdata;
  end

  assign bus.imem_req    = imem_req;
  assign bus.imem_addr   = pc_q;
  assign bus.rf_rs1_addr = rs1_addr;
  assign bus.rf_rs2_addr = rs2_addr;
  assign bus.alu_in      = R_TYPE_ALU32_INPUT'{funct7: ir_q[31:25], funct3: ir_q[14:12],
                                               rs1: op1_q, rs2: op2_q};
  assign bus.dmem_req    = dmem_req;
  assign bus.dmem_we     = dmem_req && dec.is_store;
  assign bus.dmem_addr   = mem_addr_q;
  assign bus.dmem_wdata  = op2_q;
  assign bus.rf_we       = (state_q == SAVE_IN_REGISTER) && (rd_addr != 5'd0);
  assign bus.rf_wd_addr  = rd_addr;
  assign bus.rf_wd_data  = wb_data_q;

  assign pc    = pc_q;
  assign state = state_q;
  assign error = (state_q == ERROR);

endmodule

// File: tb/tb_rv_core_sequencer.sv
// Scoreboard bench for rv_core_sequencer: memory/regfile/ALU models around the
// core, expected transfers queued at stimulus time and retired as they appear.
module tb_rv_core_sequencer;
  import rv_core_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv_core_sequencer_if bus0 ();
  rv_core_sequencer_if bus1 ();

  logic [31:0] pc0, pc1;
  logic [2:0]  st0, st1;
  logic        err0, err1;

  rv_core_sequencer #(.RESET_PC(32'h0), .MEM_TIMEOUT(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .pc(pc0), .state(st0), .error(err0)
  );

  rv_core_sequencer #(.RESET_PC(32'h0), .MEM_TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .pc(pc1), .state(st1), .error(err1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Environment models
  logic [31:0] prog [0:63];
  logic [31:0] dmem [0:255];
  logic [31:0] regs [0:31];
  int istall = 0, dstall = 0;
  int iwait = 0, dwait = 0;

  function automatic logic [31:0] alu_model(input R_TYPE_ALU32_INPUT a);
    case (a.funct3)
      3'b000:  return a.funct7[5] ? a.rs1 - a.rs2 : a.rs1 + a.rs2;
      3'b100:  return a.rs1 ^ a.rs2;
      3'b110:  return a.rs1 | a.rs2;
      3'b111:  return a.rs1 & a.rs2;
      default: return 32'h0;
    endcase
  endfunction

  assign bus0.imem_ready  = bus0.imem_req && (iwait >= istall);
  assign bus0.imem_rdata  = prog[bus0.imem_addr[7:2]];
  assign bus0.rf_rs1_data = regs[bus0.rf_rs1_addr];
  assign bus0.rf_rs2_data = regs[bus0.rf_rs2_addr];
  assign bus0.alu_result  = alu_model(bus0.alu_in);
  assign bus0.dmem_ready  = bus0.dmem_req && (dwait >= dstall);
  assign bus0.dmem_rdata  = dmem[bus0.dmem_addr[9:2]];

  assign bus1.imem_ready  = 1'b0;
  assign bus1.imem_rdata  = 32'h0;
  assign bus1.rf_rs1_data = 32'h0;
  assign bus1.rf_rs2_data = 32'h0;
  assign bus1.alu_result  = 32'h0;
  assign bus1.dmem_ready  = 1'b0;
  assign bus1.dmem_rdata  = 32'h0;

  always @(posedge clk) begin
    iwait <= (bus0.imem_req && !bus0.imem_ready) ? iwait + 1 : 0;
    dwait <= (bus0.dmem_req && !bus0.dmem_ready) ? dwait + 1 : 0;
  end

  // Scoreboard: kind 1 = rf write, 2 = load, 3 = store
  typedef struct {
    int          kind;
    logic [63:0] val;
  } sb_t;
  sb_t sbq[$];

  task automatic sb_push(input int kind, input logic [63:0] val);
    sb_t e;
    e.kind = kind;
    e.val  = val;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(input int kind, input logic [63:0] val);
    sb_t e;
    if (sbq.size() == 0) begin
      check_val("sb_unexpected", kind, 0);
    end else begin
      e = sbq.pop_front();
      check_val("sb_kind", kind, e.kind);
      check_val("sb_data", val, e.val);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus0.rf_we)
        sb_pop(1, {27'd0, bus0.rf_wd_addr, bus0.rf_wd_data});
      if (bus0.dmem_req && bus0.dmem_ready)
        sb_pop(bus0.dmem_we ? 3 : 2,
               {bus0.dmem_addr, bus0.dmem_we ? bus0.dmem_wdata : bus0.dmem_rdata});
    end
  end

  // Per-instruction observations
  int                lat, dreq_cyc, rfwe_cyc, addr_bad, we_seen;
  logic              req_c1;
  R_TYPE_ALU32_INPUT alu_c3;

  task automatic start(input logic [31:0] instr);
    prog[0] = instr;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
  endtask

  task automatic run_instr(input logic [31:0] exp_addr, input logic [31:0] target_pc,
                           input int budget);
    int n;
    n = 0;
    dreq_cyc = 0; rfwe_cyc = 0; addr_bad = 0; we_seen = 0;
    req_c1 = 1'b0;
    alu_c3 = '0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (n == 1) req_c1 = bus0.imem_req;
      if (n == 3) alu_c3 = bus0.alu_in;
      if (bus0.dmem_req) begin
        dreq_cyc++;
        if (bus0.dmem_addr !== exp_addr) addr_bad++;
        if (bus0.dmem_we) we_seen++;
      end
      if (bus0.rf_we) rfwe_cyc++;
      if (pc0 == target_pc || err0) break;
    end
    lat = n - 1;
    if (!(pc0 == target_pc || err0)) check_val("run_budget", 0, 1);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 64; i++)  prog[i] = 32'h0;
    for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
    for (int i = 0; i < 32; i++)  regs[i] = 32'h0;

    // 1: reset state, then first fetch request right after release
    prog[0] = 32'h002081B3;
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    repeat (3) @(negedge clk);
    check_val("rst_pc", pc0, 32'h0);
    check_val("rst_state", st0, READ_COMMAND);
    check_val("rst_reqs", {bus0.imem_req, bus0.dmem_req, bus0.dmem_we, bus0.rf_we, err0}, 0);
    rst_n = 1'b1;
    #1;
    check_val("rst_req_gated", bus0.imem_req, 0);

    // 2: ADD x3 = x1 + x2
    sb_push(1, {27'd0, 5'd3, 32'd12});
    run_instr(32'h0, 32'h4, 40);
    check_val("rst_req_first", {req_c1, bus0.imem_addr == 32'h4}, 2'b11);
    check_val("add_alu_ops", {alu_c3.rs1, alu_c3.rs2}, {32'd5, 32'd7});
    check_val("add_alu_fn", {alu_c3.funct7, alu_c3.funct3}, 0);
    check_val("add_lat", lat, 4);
    check_val("add_rfwe", rfwe_cyc, 1);
    check_val("add_pc", pc0, 32'h4);
    check_val("add_drain", sbq.size(), 0);

    // 3: LW x5, 8(x1) with three stall cycles
    regs[1] = 32'h100;
    dstall  = 3;
    dmem[32'h108 >> 2] = 32'hDEADBEEF;
    sb_push(2, {32'h108, 32'hDEADBEEF});
    sb_push(1, {27'd0, 5'd5, 32'hDEADBEEF});
    start(32'h0080A283);
    run_instr(32'h108, 32'h4, 40);
    check_val("lw_lat", lat, 8);
    check_val("lw_req_cycles", dreq_cyc, 4);
    check_val("lw_addr_hold", addr_bad, 0);
    check_val("lw_we", we_seen, 0);
    check_val("lw_rfwe", rfwe_cyc, 1);
    check_val("lw_pc", pc0, 32'h4);
    check_val("lw_drain", sbq.size(), 0);

    // 4: SW x2, 4(x1)
    regs[1] = 32'h200;
    regs[2] = 32'h55;
    dstall  = 0;
    sb_push(3, {32'h204, 32'h55});
    start(32'h0020A223);
    run_instr(32'h204, 32'h4, 40);
    check_val("sw_lat", lat, 4);
    check_val("sw_we", we_seen, 1);
    check_val("sw_addr", addr_bad, 0);
    check_val("sw_rfwe", rfwe_cyc, 0);
    check_val("sw_pc", pc0, 32'h4);
    check_val("sw_drain", sbq.size(), 0);

    // 5a: illegal opcode is sticky
    start(32'hFFFFFFFF);
    run_instr(32'h0, 32'h4, 40);
    check_val("ill_err", err0, 1);
    repeat (20) @(negedge clk);
    check_val("ill_sticky", {err0, st0}, {1'b1, ERROR});
    check_val("ill_frozen", {pc0, bus0.imem_req, bus0.dmem_req}, {32'h0, 2'b00});

    // 5b: misaligned load never reaches memory
    regs[1] = 32'h101;
    start(32'h0080A283);
    run_instr(32'h0, 32'h4, 40);
    check_val("mis_err", {err0, st0}, {1'b1, ERROR});
    check_val("mis_no_dreq", dreq_cyc, 0);

    // 5c: ADD to x0 writes nothing but advances
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    start(32'h00208033);
    run_instr(32'h0, 32'h4, 40);
    check_val("x0_rfwe", rfwe_cyc, 0);
    check_val("x0_pc", pc0, 32'h4);
    check_val("x0_err", err0, 0);

    // 6a: fetch timeout on the MEM_TIMEOUT=4 instance
    start(32'h0);
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (err1) break;
      if (bus1.imem_req) cnt++;
    end
    check_val("to_req_cycles", cnt, 4);
    check_val("to_err", {err1, st1}, {1'b1, ERROR});
    check_val("to_pc", pc1, 32'h0);

    // 6b: asynchronous reset while waiting on data memory
    regs[1] = 32'h100;
    dstall  = 50;
    start(32'h0080A283);
    cnt = 0;
    while (st0 != WATING_MEMORY && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check_val("mw_reached", st0, WATING_MEMORY);
    @(negedge clk);
    check_val("mw_req_before", bus0.dmem_req, 1);
    rst_n = 1'b0;
    #1;
    check_val("mw_rst_reqs", {bus0.dmem_req, bus0.dmem_we, bus0.imem_req, bus0.rf_we}, 0);
    check_val("mw_rst_state", {st0, pc0}, {READ_COMMAND, 32'h0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("mw_refetch", {bus0.imem_req, bus0.imem_addr}, {1'b1, 32'h0});
    check_val("final_drain", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
